// File: rtl/mips_pkg.sv
// mips_pkg: shared writeback-select and load-size encodings for the MIPS pipeline
package mips_pkg;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_ILL  = 2'b11;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam int DEF_LINK_REG = 31;
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the byte/half lane of a loaded word and sign- or zero-extends it
module load_extend
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane select, then extend; addr_lo[0] is irrelevant for halves
  always_comb begin
    b = addr_lo == 2'd0 ? rdata[7:0] : addr_lo == 2'd1 ? rdata[15:8] :
        addr_lo == 2'd2 ? rdata[23:16] : rdata[31:24];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data = size == SZ_BYTE ? {{(DATA_W-8){~uns & b[7]}}, b} :
           size == SZ_HALF ? {{(DATA_W-16){~uns & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/wb_select_stage.sv
// wb_select_stage: registered MEM/WB writeback select; WB_SEL_ERR_CNT_EN adds a saturating illegal-select counter
module wb_select_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = DEF_LINK_REG,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [1:0]            wb_sel,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [1:0]            addr_lo,
  input  logic                  is_jal,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  reg_write,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_we,
  output logic                  sel_err,
  output logic [ERR_CNT_W-1:0]  err_cnt
);
  localparam logic [REG_ADDR_W-1:0] LINK = REG_ADDR_W'(LINK_REG);
  logic [DATA_W-1:0]     ld_data, nxt_data;
  logic [REG_ADDR_W-1:0] nxt_rd;
  logic                  nxt_we, ill, load;
  load_extend #(.DATA_W(DATA_W)) u_ext (
    .rdata(mem_rdata), .size(mem_size), .uns(mem_unsigned), .addr_lo(addr_lo), .data(ld_data)
  );
  // next-state values for a normal load
  always_comb begin
    nxt_data = wb_sel == WB_ALU ? alu_result : wb_sel == WB_MEM ? ld_data :
               wb_sel == WB_LINK ? pc_plus4 : '0;
    nxt_rd = (wb_sel == WB_LINK && is_jal) ? LINK : rd_in;
    nxt_we = in_valid & reg_write & (wb_sel != WB_ILL) & (nxt_rd != '0);
    load = ~flush & ~stall;
    ill = load & in_valid & (wb_sel == WB_ILL);
  end
  // stage register: flush kills valid/we, stall holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
      sel_err  <= 1'b0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
    end else if (!stall) begin
      wb_valid <= in_valid;
      wb_data  <= nxt_data;
      wb_rd    <= nxt_rd;
      wb_we    <= nxt_we;
      if (ill) sel_err <= 1'b1;
    end
  end
`ifdef WB_SEL_ERR_CNT_EN
  // saturating count of illegal selects that reach the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (ill && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
  end
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_select_stage.sv
// tb_wb_select_stage: table-driven vectors plus stall/flush/illegal/reset sequences
module tb_wb_select_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid, mem_unsigned, is_jal, reg_write, stall, flush;
  logic [31:0] alu_result, mem_rdata, pc_plus4;
  logic [1:0]  wb_sel, mem_size, addr_lo;
  logic [4:0]  rd_in;
  logic        wb_valid, wb_we, sel_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [7:0]  err_cnt;
  int n_run = 0, n_fail = 0;

  typedef struct {
    logic iv; logic [31:0] alu, mem, pc; logic [1:0] sel, size; logic uns;
    logic [1:0] lo; logic jal; logic [4:0] rd; logic rw;
    logic [31:0] e_data; logic [4:0] e_rd; logic e_we, e_valid;
  } vec_t;
  vec_t vt[14];

  wb_select_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .pc_plus4(pc_plus4), .wb_sel(wb_sel), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr_lo(addr_lo), .is_jal(is_jal), .rd_in(rd_in),
    .reg_write(reg_write), .stall(stall), .flush(flush), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .sel_err(sel_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.iv; alu_result = v.alu; mem_rdata = v.mem; pc_plus4 = v.pc;
    wb_sel = v.sel; mem_size = v.size; mem_unsigned = v.uns; addr_lo = v.lo;
    is_jal = v.jal; rd_in = v.rd; reg_write = v.rw;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input logic [4:0] rd,
                         input logic we, input logic vld);
    chk({tag, ".data"}, wb_data, d);
    chk({tag, ".rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, ".we"}, 32'(wb_we), 32'(we));
    chk({tag, ".valid"}, 32'(wb_valid), 32'(vld));
  endtask

  function automatic vec_t mk(logic iv, logic [31:0] alu, mem, pc, logic [1:0] sel, size,
                              logic uns, logic [1:0] lo, logic jal, logic [4:0] rd, logic rw,
                              logic [31:0] ed, logic [4:0] erd, logic ewe, logic ev);
    vec_t v;
    v.iv = iv; v.alu = alu; v.mem = mem; v.pc = pc; v.sel = sel; v.size = size; v.uns = uns;
    v.lo = lo; v.jal = jal; v.rd = rd; v.rw = rw; v.e_data = ed; v.e_rd = erd; v.e_we = ewe;
    v.e_valid = ev;
    return v;
  endfunction

  initial begin
    vec_t v;
    vt[0]  = mk(1, 0, 32'h1280_3456, 0, 2'b01, 2'b10, 0, 2, 0, 8, 1, 32'hFFFF_FF80, 8, 1, 1);
    vt[1]  = mk(1, 0, 32'hBEEF_0001, 0, 2'b01, 2'b01, 1, 2, 0, 8, 1, 32'h0000_BEEF, 8, 1, 1);
    vt[2]  = mk(1, 0, 32'h1234_8001, 0, 2'b01, 2'b01, 0, 0, 0, 8, 1, 32'hFFFF_8001, 8, 1, 1);
    vt[3]  = mk(1, 0, 32'hF000_0000, 0, 2'b01, 2'b10, 1, 3, 0, 8, 1, 32'h0000_00F0, 8, 1, 1);
    vt[4]  = mk(1, 0, 32'h0000_007F, 0, 2'b01, 2'b10, 0, 0, 0, 8, 1, 32'h0000_007F, 8, 1, 1);
    vt[5]  = mk(1, 0, 32'h7FFF_0000, 0, 2'b01, 2'b01, 0, 3, 0, 8, 1, 32'h0000_7FFF, 8, 1, 1);
    vt[6]  = mk(1, 0, 32'hDEAD_BEEF, 0, 2'b01, 2'b00, 0, 1, 0, 8, 1, 32'hDEAD_BEEF, 8, 1, 1);
    vt[7]  = mk(1, 0, 32'hCAFE_F00D, 0, 2'b01, 2'b11, 0, 1, 0, 8, 1, 32'hCAFE_F00D, 8, 1, 1);
    vt[8]  = mk(1, 32'h1122_3344, 0, 0, 2'b00, 0, 0, 0, 0, 5, 1, 32'h1122_3344, 5, 1, 1);
    vt[9]  = mk(1, 0, 0, 32'h0040_0008, 2'b10, 0, 0, 0, 1, 0, 1, 32'h0040_0008, 31, 1, 1);
    vt[10] = mk(1, 0, 0, 32'h0040_0008, 2'b10, 0, 0, 0, 0, 0, 1, 32'h0040_0008, 0, 0, 1);
    vt[11] = mk(1, 32'h0000_0077, 0, 0, 2'b00, 0, 0, 0, 1, 7, 1, 32'h0000_0077, 7, 1, 1);
    vt[12] = mk(0, 32'h0000_0055, 0, 0, 2'b00, 0, 0, 0, 0, 4, 1, 32'h0000_0055, 4, 0, 0);
    vt[13] = mk(1, 32'h0000_0066, 0, 0, 2'b00, 0, 0, 0, 0, 4, 0, 32'h0000_0066, 4, 0, 1);

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    stall = 0; flush = 0;
    #12;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.sel_err", 32'(sel_err), 0);
    chk("reset.err_cnt", 32'(err_cnt), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk) drive(vt[i]);
      step();
      chk_out($sformatf("vec%0d", i), vt[i].e_data, vt[i].e_rd, vt[i].e_we, vt[i].e_valid);
    end
    chk("vec.sel_err", 32'(sel_err), 0);

    @(negedge clk) drive(mk(1, 32'hA5A5_A5A5, 0, 0, 2'b00, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0));
    step();
    chk_out("stall_load", 32'hA5A5_A5A5, 9, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1; alu_result = 32'h100 + i; rd_in = 5'(12 + i); in_valid = i[0];
      step();
      chk_out($sformatf("stall%0d", i), 32'hA5A5_A5A5, 9, 1, 1);
    end
    @(negedge clk) flush = 1;
    step();
    chk_out("stall_flush", 32'hA5A5_A5A5, 9, 0, 0);

    @(negedge clk) begin stall = 0; drive(mk(1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0)); end
    repeat (3) step();
    chk("ill_flush.sel_err", 32'(sel_err), 0);
    chk("ill_flush.err_cnt", 32'(err_cnt), 0);
    chk("ill_flush.valid", 32'(wb_valid), 0);

    @(negedge clk) flush = 0;
    repeat (3) step();
    chk_out("ill", 0, 3, 0, 1);
    chk("ill.sel_err", 32'(sel_err), 1);
`ifdef WB_SEL_ERR_CNT_EN
    chk("ill.err_cnt", 32'(err_cnt), 3);
`else
    chk("ill.err_cnt", 32'(err_cnt), 0);
`endif
    @(negedge clk) drive(mk(1, 32'h0000_0042, 0, 0, 2'b00, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0));
    step();
    chk_out("after_ill", 32'h42, 6, 1, 1);
    chk("sticky.sel_err", 32'(sel_err), 1);

    @(negedge clk) stall = 1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    chk("async_rst.sel_err", 32'(sel_err), 0);
    chk("async_rst.err_cnt", 32'(err_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Registered MEM/WB writeback stage for the MIPS pipeline.
- Selects the writeback value from the ALU result, the extended load data, or the link address (PC+4), and registers it together with destination register and write enable.
- Sits between data memory and the register file.
- Parametrised successor to the unregistered writeback-select mux: adds width generalisation, load extension, link-register forcing, stall/flush and illegal-select detection.

Parameters:
- DATA_W, 32, datapath width (multiple of 8, ≥32)
- REG_ADDR_W, 5, register-file address width
- LINK_REG, 31, destination forced for JAL
- ERR_CNT_W, 8, width of illegal-select counter (optional feature only)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM-stage instruction valid
- alu_result  in  DATA_W  ALU result
- mem_rdata  in  DATA_W  raw word from data memory
- pc_plus4  in  DATA_W  link address
- wb_sel  in  2  00=ALU, 01=MEM, 10=LINK, 11=illegal
- mem_size  in  2  00=word, 01=half, 10=byte, 11=word
- mem_unsigned  in  1  1=zero-extend, 0=sign-extend
- addr_lo  in  2  byte offset of load address
- is_jal  in  1  force destination to LINK_REG
- rd_in  in  REG_ADDR_W  destination register
- reg_write  in  1  instruction writes register file
- stall  in  1  hold stage contents
- flush  in  1  kill instruction entering stage
- wb_valid  out  1  registered valid
- wb_data  out  DATA_W  registered writeback value
- wb_rd  out  REG_ADDR_W  registered destination
- wb_we  out  1  registered register-file write enable
- sel_err  out  1  sticky illegal-select flag
- err_cnt  out  ERR_CNT_W  illegal-select count (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): wb_valid, wb_data, wb_rd, wb_we, sel_err, err_cnt = 0 immediately. Reset mid-stall or mid-flush wins over everything.
- Latency: 1 cycle. Inputs sampled on rising clk; outputs are registered only, with no combinational path from input to output.
- Priority each edge: flush > stall > load.
  - flush=1: wb_valid=0, wb_we=0; wb_data and wb_rd hold.
  - stall=1 (no flush): all outputs hold.
  - Otherwise: load the new values below.
- Load extension, applied only when wb_sel=01:
  - Byte: lane = addr_lo; bits [8*lane+7 : 8*lane] extended to DATA_W.
  - Half: lane = addr_lo[1]; bits [16*lane+15 : 16*lane] extended to DATA_W. addr_lo[0] is ignored (alignment is checked upstream).
  - Word or mem_size=11: mem_rdata passes through unchanged.
  - Extension is sign or zero per mem_unsigned.
- Data select:
  - 00 → alu_result
  - 01 → extended load data
  - 10 → pc_plus4
  - 11 → 0
- Destination: wb_rd = LINK_REG when wb_sel=10 and is_jal=1; otherwise rd_in. is_jal with any other wb_sel is ignored.
- Write enable: wb_we = in_valid & reg_write & (wb_sel≠11) & (destination≠0).
- wb_valid = in_valid on a normal load.
- Illegal select: on a normal load with in_valid=1 and wb_sel=11, sel_err is set to 1 and stays set until reset. A flushed or stalled illegal select does not set it.

Optional Feature:
- Macro WB_SEL_ERR_CNT_EN.
- Defined: err_cnt increments on each event that sets or would set sel_err (valid, loaded, wb_sel=11). It saturates at all-ones.
- Undefined: err_cnt is tied to 0 and no counter flops are built. sel_err behaviour is identical in both builds.

Decomposition:
- Shared package (mips_pkg): wb_sel encodings (WB_ALU, WB_MEM, WB_LINK, WB_ILL), mem_size encodings (SZ_WORD, SZ_HALF, SZ_BYTE), default LINK_REG.
- One sub-module: load_extend, combinational, containing the lane select and sign/zero extension. It is parametrised by DATA_W.

Test Plan:
- Byte, sign-extended: rst_n released; in_valid=1, reg_write=1, wb_sel=01, mem_size=10, mem_unsigned=0, addr_lo=2, mem_rdata=0x12_80_34_56, rd_in=8 → next cycle wb_data=0xFFFFFF80, wb_rd=8, wb_we=1.
- Half, zero-extended: mem_size=01, mem_unsigned=1, addr_lo=2, mem_rdata=0xBEEF_0001 → wb_data=0x0000BEEF.
- JAL link: wb_sel=10, is_jal=1, pc_plus4=0x00400008, rd_in=0 → wb_rd=31, wb_data=0x00400008, wb_we=1. Repeat with is_jal=0, rd_in=0 → wb_rd=0, wb_we=0.
- Stall and flush: load alu_result=0xA5A5A5A5, then stall=1 for 3 cycles with changing inputs → outputs hold 0xA5A5A5A5. Then stall=1 and flush=1 → wb_valid=0, wb_we=0.
- Illegal select: wb_sel=11 valid for 3 loads → wb_we=0, wb_data=0, sel_err=1 sticky; err_cnt=3 with macro, 0 without. The same stimulus with flush=1 leaves sel_err=0.
- Async reset mid-stall: assert rst_n=0 between clock edges → all outputs 0 before the next edge.
